// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite write subordinate: B-channel response codes and FSM states.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        COLLECT = 1'b0,
        RESP    = 1'b1
    } wr_state_e;

endpackage

// File: rtl/axil_wr_regfile.sv
// Strobe-masked register array. Byte lanes with a clear strobe keep their old value.
module axil_wr_regfile #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned STRB_W   = DATA_W / 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         we,
    input  logic [$clog2(NUM_REGS)-1:0]  idx,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [STRB_W-1:0]            wstrb,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            regs <= '0;
        end else if (we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign reg_q = regs;

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI-Lite write subordinate: collects AW and W in either order, commits into a register file.
// Define AXIL_WR_RANGE_CHECK_EN to answer out-of-range addresses with SLVERR and skip the write.
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned STRB_W   = DATA_W / 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_W-1:0]            WDATA,
    input  logic [STRB_W-1:0]            WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]  wr_idx
);

    localparam int unsigned LSB   = $clog2(STRB_W);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    wr_state_e          state;
    resp_e              bresp_q;
    logic               rst_done;
    logic               aw_full;
    logic               w_full;
    logic [ADDR_W-1:0]  aw_addr;
    logic [DATA_W-1:0]  w_data;
    logic [STRB_W-1:0]  w_strb;

    logic               aw_hs;
    logic               w_hs;
    logic               commit;
    logic               wr_err;
    logic               reg_we;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  data_sel;
    logic [STRB_W-1:0]  strb_sel;
    logic [IDX_W-1:0]   idx;
    logic               unused_addr_bits;

    assign AWREADY = rst_done & ~aw_full & (state == COLLECT);
    assign WREADY  = rst_done & ~w_full & (state == COLLECT);
    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;

    // A channel handshaking this cycle is used directly; otherwise the held copy.
    assign addr_sel = aw_full ? aw_addr : AWADDR;
    assign data_sel = w_full  ? w_data  : WDATA;
    assign strb_sel = w_full  ? w_strb  : WSTRB;

    assign commit = (state == COLLECT) & (aw_full | aw_hs) & (w_full | w_hs);
    assign idx    = addr_sel[LSB +: IDX_W];

`ifdef AXIL_WR_RANGE_CHECK_EN
    assign wr_err           = |(addr_sel >> (LSB + IDX_W));
    assign unused_addr_bits = ^addr_sel[LSB-1:0];
`else
    assign wr_err           = 1'b0;
    assign unused_addr_bits = ^{addr_sel[LSB-1:0], addr_sel[ADDR_W-1:LSB+IDX_W]};
`endif

    assign reg_we = commit & ~wr_err;
    assign BRESP  = bresp_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= COLLECT;
            bresp_q  <= OKAY;
            BVALID   <= 1'b0;
            rst_done <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
        end else begin
            rst_done <= 1'b1;
            wr_pulse <= 1'b0;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= AWADDR;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            unique case (state)
                COLLECT: begin
                    if (commit) begin
                        state  <= RESP;
                        BVALID <= 1'b1;
                        if (wr_err) begin
                            bresp_q <= SLVERR;
                        end else begin
                            bresp_q  <= OKAY;
                            wr_pulse <= 1'b1;
                            wr_idx   <= idx;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        state   <= COLLECT;
                        BVALID  <= 1'b0;
                        aw_full <= 1'b0;
                        w_full  <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    axil_wr_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .STRB_W   (STRB_W)
    ) u_regfile (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .we      (reg_we),
        .idx     (idx),
        .wdata   (data_sel),
        .wstrb   (strb_sel),
        .reg_q   (reg_q)
    );

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Self-checking bench for axi_lite_write_slave: directed scenarios plus randomized writes vs a model.
module tb_axi_lite_write_slave;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned STRB_W   = 8;
    localparam int unsigned NUM_REGS = 16;

    logic                        ACLK = 1'b0;
    logic                        ARESETn = 1'b0;
    logic [ADDR_W-1:0]           AWADDR = '0;
    logic                        AWVALID = 1'b0;
    logic                        AWREADY;
    logic [DATA_W-1:0]           WDATA = '0;
    logic [STRB_W-1:0]           WSTRB = '0;
    logic                        WVALID = 1'b0;
    logic                        WREADY;
    logic [1:0]                  BRESP;
    logic                        BVALID;
    logic                        BREADY = 1'b0;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;
    logic                        wr_pulse;
    logic [3:0]                  wr_idx;

    int n_checks = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    logic [63:0] m_regs [NUM_REGS];

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) if (wr_pulse) pulse_cnt <= pulse_cnt + 1;

    axi_lite_write_slave dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .wr_idx   (wr_idx)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            check_eq($sformatf("%s[%0d]", tag, i), reg_q[i*DATA_W +: DATA_W], m_regs[i]);
        end
    endtask

    // Reference: word address selects a register; bytes merge under the strobe mask.
    task automatic model_write(input logic [31:0] addr, input logic [63:0] data,
                               input logic [7:0] strb, output logic [1:0] resp,
                               output logic wrote, output int idx);
        int unsigned word;
        word  = addr / 8;
        idx   = int'(word % NUM_REGS);
        resp  = 2'b00;
        wrote = 1'b1;
`ifdef AXIL_WR_RANGE_CHECK_EN
        if (word >= NUM_REGS) begin
            resp  = 2'b10;
            wrote = 1'b0;
        end
`endif
        if (wrote) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        ARESETn = 1'b0;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        repeat (cycles) @(posedge ACLK);
        #1;
        check_eq("rst_bvalid", 64'(BVALID), 0);
        check_eq("rst_bresp", 64'(BRESP), 0);
        check_eq("rst_awready", 64'(AWREADY), 0);
        check_eq("rst_wready", 64'(WREADY), 0);
        check_eq("rst_wr_pulse", 64'(wr_pulse), 0);
        check_eq("rst_wr_idx", 64'(wr_idx), 0);
        check_regs("rst_reg");
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        check_eq("rel_awready", 64'(AWREADY), 1);
        check_eq("rel_wready", 64'(WREADY), 1);
    endtask

    // One full transaction; delays are in cycles from the start of the call.
    task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int aw_d, input int w_d,
                            input int b_d, output int bv_cycles);
        logic aw_done, w_done, b_done, resp_seen;
        logic aw_hs, w_hs, b_hs;
        logic [1:0] got_resp, first_resp, exp_resp;
        logic wrote;
        int idx, cyc, viol, p0;
        aw_done = 0; w_done = 0; b_done = 0; resp_seen = 0;
        got_resp = '0; first_resp = '0;
        cyc = 0; viol = 0; bv_cycles = 0;
        model_write(addr, data, strb, exp_resp, wrote, idx);
        p0 = pulse_cnt;
        while (!b_done && cyc < 100) begin
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = !aw_done && cyc >= aw_d;
            WVALID  = !w_done && cyc >= w_d;
            BREADY  = cyc >= b_d;
            if (BVALID) begin
                bv_cycles++;
                if (!resp_seen) begin
                    first_resp = BRESP;
                    resp_seen  = 1;
                end else if (BRESP !== first_resp) begin
                    viol++;
                end
                if (AWREADY || WREADY) viol++;
            end else begin
                if (w_done && WREADY) viol++;
                if (aw_done && AWREADY) viol++;
            end
            aw_hs    = AWVALID && AWREADY;
            w_hs     = WVALID && WREADY;
            b_hs     = BVALID && BREADY;
            got_resp = BRESP;
            @(posedge ACLK);
            #1;
            cyc++;
            if (b_hs) b_done = 1;
            else if ((aw_hs || aw_done) && (w_hs || w_done) && !(aw_done && w_done))
                check_eq("bvalid_latency", 64'(BVALID), 1);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        if (!b_done) check_eq("b_timeout", 64'(b_done), 1);
        else check_eq("bresp", 64'(got_resp), 64'(exp_resp));
        check_eq("protocol", 64'(viol), 0);
        check_eq("wr_pulse_cnt", 64'(pulse_cnt - p0), 64'(wrote));
        if (wrote) check_eq("wr_idx", 64'(wr_idx), 64'(idx));
        check_regs("reg");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bvc, viol, idx;
        logic [1:0] r0, er;
        logic wr;

        apply_reset(3);

        do_write(32'h08, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, bvc);
        check_eq("simul_bv_cycles", 64'(bvc), 1);

        do_write(32'h08, 64'h11111111_22222222, 8'h0F, 3, 0, 0, bvc);
        check_eq("partial_reg1", reg_q[1*DATA_W +: DATA_W], 64'hDEADBEEF_22222222);

        do_write(32'h80, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0, bvc);

        // Backpressure with a second AW/W waiting.
        AWADDR = 32'h10; WDATA = 64'hA5A5_0000_1234_5678; WSTRB = 8'hFF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        model_write(32'h10, 64'hA5A5_0000_1234_5678, 8'hFF, er, wr, idx);
        @(posedge ACLK); #1;
        check_eq("bp_bvalid_rise", 64'(BVALID), 1);
        r0 = BRESP;
        AWADDR = 32'h18; WDATA = 64'h5A5A_FFFF_8765_4321; WSTRB = 8'hF0;
        viol = 0;
        repeat (5) begin
            if (!BVALID || BRESP !== r0 || AWREADY || WREADY) viol++;
            @(posedge ACLK); #1;
        end
        check_eq("bp_hold", 64'(viol), 0);
        check_eq("bp_resp", 64'(r0), 64'(er));
        check_regs("bp_reg_a");
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        check_eq("bp_b_done", 64'(BVALID), 0);
        check_eq("bp_awready", 64'(AWREADY), 1);
        model_write(32'h18, 64'h5A5A_FFFF_8765_4321, 8'hF0, er, wr, idx);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        check_eq("bp_second_bvalid", 64'(BVALID), 1);
        check_regs("bp_reg_b");
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        check_eq("bp_second_done", 64'(BVALID), 0);

        // Reset while the response is pending.
        AWADDR = 32'h20; WDATA = 64'hFACE_B00C_0BAD_F00D; WSTRB = 8'hFF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        check_eq("rr_bvalid", 64'(BVALID), 1);
        #2;
        ARESETn = 0;
        #1;
        check_eq("rr_bvalid_async", 64'(BVALID), 0);
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        check_regs("rr_reg");
        @(posedge ACLK); #1;
        ARESETn = 1;
        @(posedge ACLK); #1;
        do_write(32'h28, 64'h0000_1111_2222_3333, 8'hC3, 1, 0, 1, bvc);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [63:0] d;
            logic [7:0]  s;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(32'h80, 32'h3FF);
            else a = $urandom_range(0, 32'h7F);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: s = 8'h00;
                1, 2: s = 8'hFF;
                default: s = 8'($urandom);
            endcase
            do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)), bvc);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_write_slave.md
# axi_lite_write_slave

AXI-Lite write subordinate. It accepts the write address (AW) and write data (W) channels independently, in either order. It commits byte-strobed writes into a local register array and returns a write response on B. The block sits directly downstream of the testbench/SoC AXI-Lite write master and terminates its AW/W/B traffic. It exposes the register contents and a one-cycle write event to downstream logic.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 64, data width; must be 32 or 64.
- STRB_W, DATA_W/8, byte-strobe width.
- NUM_REGS, 16, register count; power of two, at least 2.
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWADDR  in  ADDR_W  write address.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  STRB_W  byte strobes.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BRESP  out  2  write response.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- reg_q  out  NUM_REGS*DATA_W  flattened register array; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse  out  1  one-cycle pulse on each committed write.
- wr_idx  out  $clog2(NUM_REGS)  index of the last committed write.

## Operation
- **Index decode:**
  - LSB = $clog2(STRB_W).
  - idx = AWADDR[LSB +: $clog2(NUM_REGS)].
  - Low LSB address bits are ignored; no misalignment error.
  - Out of range when (AWADDR >> LSB) >= NUM_REGS.
- **Holding registers:**
  - aw_full / aw_addr capture AW on an AW handshake.
  - w_full / w_data / w_strb capture W on a W handshake.
- **FSM state COLLECT:**
  - AWREADY = rst_done & ~aw_full.
  - WREADY = rst_done & ~w_full.
  - An address counts as available when (aw_full | AW handshake this cycle); data likewise with W.
  - When both are available at a rising edge, the write commits at that edge and the FSM moves to RESP.
  - On commit: for each set strobe bit b, byte b of the target register takes the corresponding WDATA/held-data byte. Clear strobe bits leave the byte unchanged.
  - On commit: BVALID←1, BRESP←response, wr_pulse←1, wr_idx←idx.
  - All-zero WSTRB is legal; it returns OKAY and changes no register.
- **FSM state RESP:**
  - AWREADY = WREADY = 0.
  - BVALID and BRESP are held stable until BREADY.
  - On the B handshake: BVALID←0, aw_full←0, w_full←0, FSM → COLLECT.
- **Response codes** use resp_e: OKAY 2'b00 or SLVERR 2'b10 (see Configuration).
- Only one transaction is outstanding; no pipelining of a second AW/W while in RESP.

## Timing
- **Reset (ARESETn low, takes effect immediately):**
  - BVALID=0, BRESP=00, wr_pulse=0, wr_idx=0.
  - All registers 0, holding flags 0, FSM=COLLECT.
  - rst_done=0, so AWREADY=WREADY=0.
  - rst_done sets at the first rising edge after release; ready rises one cycle after deassertion.
- **Latency:**
  - BVALID rises in the cycle after the later of the AW/W handshakes.
  - With AW and W in the same cycle and BREADY=1: handshake at edge N, BVALID high N→N+1, B handshake at N+1, AWREADY/WREADY high again from N+1.
  - Minimum throughput: one write per 2 cycles.
- **Register timing:** reg_q updates at the commit edge. wr_pulse is high for exactly the one cycle after commit.
- **Reset mid-transaction:** any in-flight AW/W is discarded and no partial write remains; BVALID drops asynchronously.
- **BREADY during COLLECT** is ignored.

## Configuration
- **AXIL_WR_RANGE_CHECK_EN defined:**
  - An out-of-range address returns SLVERR.
  - No register is written.
  - wr_pulse stays 0.
- **AXIL_WR_RANGE_CHECK_EN undefined:**
  - No range check is performed.
  - idx wraps modulo NUM_REGS.
  - The write always commits and the response is always OKAY.

## Structure
- **Package axi_lite_pkg:**
  - resp_e enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_e enum: COLLECT, RESP.
- **Sub-module axil_wr_regfile:**
  - Strobe-masked register array: inputs we, idx, wdata, wstrb.
  - Output: flattened reg_q.
  - Same asynchronous active-low reset to 0.
- The top level holds the holding registers, the FSM and the B channel.

## Test plan
1. **Reset:** drive ARESETn=0 for 3 cycles. Expect BVALID=0, BRESP=00, AWREADY=WREADY=0, reg_q all 0. Expect AWREADY=1 one cycle after release.
2. **Simultaneous AW+W:** AWADDR=0x08, WDATA=0xDEADBEEF_CAFEF00D, WSTRB=0xFF, BREADY=1. Expect BVALID for exactly 1 cycle, BRESP=00, reg[1]=0xDEADBEEF_CAFEF00D, wr_idx=1, one wr_pulse.
3. **W before AW, partial strobe:** W leads AW by 3 cycles, WDATA=0x11111111_22222222, WSTRB=0x0F, AWADDR=0x08. Expect WREADY=0 while waiting, then reg[1]=0xDEADBEEF_22222222.
4. **Out of range:** AWADDR=0x80 (index 16) with the macro defined. Expect BRESP=10, reg_q unchanged, no wr_pulse. With the macro undefined, expect BRESP=00 and reg[0] written.
5. **Backpressure:** BREADY=0 for 5 cycles with a second AW/W presented. Expect BVALID held, BRESP stable, AWREADY=WREADY=0. After BREADY=1, the second write commits 1 cycle later.
6. **Reset in RESP:** pulse ARESETn low while BVALID=1. Expect BVALID=0 immediately and reg_q=0. The next write after release completes normally.
